// File: rtl/draw_lines_pkg.sv
// draw_lines_pkg
//   Shared types and widths for the multi-segment line overlay renderer.
//   line_seg_t holds one normalised segment slot (x1 <= x2) together with
//   its precomputed deltas and a valid bit.
package draw_lines_pkg;

    localparam int H_W    = 11;
    localparam int V_W    = 10;
    localparam int PROD_W = 24;

    typedef struct packed {
        logic [H_W-1:0]        x1;
        logic [V_W-1:0]        y1;
        logic [H_W-1:0]        x2;
        logic [V_W-1:0]        y2;
        logic [H_W-1:0]        dx;
        logic signed [H_W-1:0] dy;
        logic                  valid;
    } line_seg_t;

    // Slot index width; a single-slot build still needs a 1-bit index port.
    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_hit_test.sv
// line_hit_test
//   One segment slot's slice of the pixel pipeline. Takes the S1 pixel
//   registers from the top plus the slot's active segment, forms the
//   cross-product terms, registers them, and produces the slot's hit bit.
//   Ports:
//     clk_in, rst_in   pixel clock, synchronous active-high reset
//     hcount, vcount   S1-registered pixel coordinates
//     seg              active-bank segment for this slot
//     hit              combinational hit from the S2 registers (used by S3)
module line_hit_test
    import draw_lines_pkg::*;
#(
    parameter int TOL = 500
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic [H_W-1:0] hcount,
    input  logic [V_W-1:0] vcount,
    input  line_seg_t      seg,
    output logic           hit
);

    localparam int DIFF_W = PROD_W + 1;

    function automatic logic [DIFF_W-1:0] abs_diff(input logic signed [PROD_W-1:0] a,
                                                   input logic signed [PROD_W-1:0] b);
        logic signed [DIFF_W-1:0] d;
        d = DIFF_W'(a) - DIFF_W'(b);
        return d[DIFF_W-1] ? DIFF_W'(-d) : DIFF_W'(d);
    endfunction

    // ---- S1: offsets from the first endpoint, range flags, products ----
    logic signed [H_W:0]      hd_p0;
    logic signed [V_W:0]      vd_p0;
    logic [V_W-1:0]           y_lo_p0;
    logic [V_W-1:0]           y_hi_p0;
    logic                     vert_p0;
    logic                     rng_p0;
    logic signed [PROD_W-1:0] p1_p0;
    logic signed [PROD_W-1:0] p2_p0;

    assign hd_p0   = $signed({1'b0, hcount}) - $signed({1'b0, seg.x1});
    assign vd_p0   = $signed({1'b0, vcount}) - $signed({1'b0, seg.y1});
    assign y_lo_p0 = (seg.y1 <= seg.y2) ? seg.y1 : seg.y2;
    assign y_hi_p0 = (seg.y1 <= seg.y2) ? seg.y2 : seg.y1;
    assign vert_p0 = (seg.dx == '0);
    // A vertical segment degenerates the cross product to zero everywhere
    // on its column, so its extent is bounded by the y range instead.
    assign rng_p0  = (hcount >= seg.x1) && (hcount <= seg.x2) &&
                     (!vert_p0 || ((vcount >= y_lo_p0) && (vcount <= y_hi_p0)));
    assign p1_p0   = PROD_W'(vd_p0) * $signed(PROD_W'({1'b0, seg.dx}));
    assign p2_p0   = PROD_W'(hd_p0) * PROD_W'(seg.dy);

    // ---- S2: registered cross-product terms and flags ----
    logic signed [PROD_W-1:0] p1_p1;
    logic signed [PROD_W-1:0] p2_p1;
    logic                     rng_p1;
    logic                     vert_p1;
    logic                     vld_p1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            p1_p1   <= '0;
            p2_p1   <= '0;
            rng_p1  <= 1'b0;
            vert_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            p1_p1   <= p1_p0;
            p2_p1   <= p2_p0;
            rng_p1  <= rng_p0;
            vert_p1 <= vert_p0;
            vld_p1  <= seg.valid;
        end
    end

    // ---- S3: tolerance test feeding the top-level priority encoder ----
    assign hit = vld_p1 && rng_p1 &&
                 (vert_p1 || (abs_diff(p1_p1, p2_p1) <= DIFF_W'(TOL)));

endmodule

// File: rtl/draw_lines_multi.sv
// draw_lines_multi
//   Multi-segment line overlay renderer. Holds NUM_LINES segment slots in a
//   double-buffered bank (pending written by the placement logic, active
//   read by the pixel pipeline; pending copies to active at pixel (0,0)).
//   Every pixel is tested against all active slots in a fixed 3-cycle
//   pipeline and the lowest-numbered hit slot selects the output colour.
//   Optional feature macro: DRAW_LINES_PER_LINE_COLOR_EN adds color_in and
//   a per-slot colour; otherwise every hit uses COLOR.
//   Ports:
//     clk_in, rst_in                  pixel clock, sync active-high reset
//     hcount_in, vcount_in            current pixel
//     place_valid, place_slot         write a segment into a pending slot
//     x_in_1, y_in_1, x_in_2, y_in_2  segment endpoints
//     color_in                        slot colour (feature macro only)
//     clear_all                       invalidate every pending slot
//     hit_out, hit_slot_out           hit flag / lowest hit slot, 3 cycles late
//     red_out, green_out, blue_out    pixel colour, 0 on miss
module draw_lines_multi
    import draw_lines_pkg::*;
#(
    parameter int          NUM_LINES = 4,
    parameter int          TOL       = 500,
    parameter logic [23:0] COLOR     = 24'hFF_FF_FF
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [H_W-1:0]                hcount_in,
    input  logic [V_W-1:0]                vcount_in,
    input  logic                          place_valid,
    input  logic [slot_w(NUM_LINES)-1:0]  place_slot,
    input  logic [H_W-1:0]                x_in_1,
    input  logic [H_W-1:0]                x_in_2,
    input  logic [V_W-1:0]                y_in_1,
    input  logic [V_W-1:0]                y_in_2,
`ifdef DRAW_LINES_PER_LINE_COLOR_EN
    input  logic [23:0]                   color_in,
`endif
    input  logic                          clear_all,
    output logic                          hit_out,
    output logic [slot_w(NUM_LINES)-1:0]  hit_slot_out,
    output logic [7:0]                    red_out,
    output logic [7:0]                    green_out,
    output logic [7:0]                    blue_out
);

    localparam int SLOT_W = slot_w(NUM_LINES);

    line_seg_t pend_bank [NUM_LINES];
    line_seg_t act_bank  [NUM_LINES];
    line_seg_t new_seg;
    logic      frame_start;
    logic      slot_ok;

    assign frame_start = (hcount_in == '0) && (vcount_in == '0);
    assign slot_ok     = place_valid && (32'(place_slot) < NUM_LINES);

    // Endpoints are swapped so x1 <= x2; on an x tie the order is kept.
    always_comb begin
        new_seg = '0;
        if (x_in_1 > x_in_2) begin
            new_seg.x1 = x_in_2;
            new_seg.y1 = y_in_2;
            new_seg.x2 = x_in_1;
            new_seg.y2 = y_in_1;
        end else begin
            new_seg.x1 = x_in_1;
            new_seg.y1 = y_in_1;
            new_seg.x2 = x_in_2;
            new_seg.y2 = y_in_2;
        end
        new_seg.dx    = new_seg.x2 - new_seg.x1;
        new_seg.dy    = $signed({1'b0, new_seg.y2}) - $signed({1'b0, new_seg.y1});
        new_seg.valid = 1'b1;
    end

    // The commit copies pending as it stood before this cycle's write, so a
    // placement on the frame-start cycle waits for the following frame.
    // A same-cycle placement overrides clear_all for its own slot.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                pend_bank[i].valid <= 1'b0;
                act_bank[i].valid  <= 1'b0;
            end
        end else begin
            if (frame_start) begin
                act_bank <= pend_bank;
            end
            for (int i = 0; i < NUM_LINES; i++) begin
                if (clear_all) begin
                    pend_bank[i].valid <= 1'b0;
                end
                if (slot_ok && (32'(place_slot) == i)) begin
                    pend_bank[i] <= new_seg;
                end
            end
        end
    end

`ifdef DRAW_LINES_PER_LINE_COLOR_EN
    logic [23:0] pend_col [NUM_LINES];
    logic [23:0] act_col  [NUM_LINES];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            if (frame_start) begin
                act_col <= pend_col;
            end
            for (int i = 0; i < NUM_LINES; i++) begin
                if (slot_ok && (32'(place_slot) == i)) begin
                    pend_col[i] <= color_in;
                end
            end
        end
    end
`endif

    // ---- S1: pixel registers; the active bank is read from here on ----
    logic [H_W-1:0] h_p0;
    logic [V_W-1:0] v_p0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            h_p0 <= '0;
            v_p0 <= '0;
        end else begin
            h_p0 <= hcount_in;
            v_p0 <= vcount_in;
        end
    end

    // ---- S2: per-slot product registers live inside line_hit_test ----
    logic [NUM_LINES-1:0] hit_p1;

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_slot
        line_hit_test #(
            .TOL (TOL)
        ) u_test (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .hcount (h_p0),
            .vcount (v_p0),
            .seg    (act_bank[g]),
            .hit    (hit_p1[g])
        );
    end

`ifdef DRAW_LINES_PER_LINE_COLOR_EN
    // Colour travels with the products so a commit cannot recolour pixels
    // already in flight.
    logic [23:0] col_p1 [NUM_LINES];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                col_p1[i] <= '0;
            end
        end else begin
            col_p1 <= act_col;
        end
    end
`endif

    // ---- S3: priority encode lowest hit slot, register outputs ----
    logic              any_hit_p1;
    logic [SLOT_W-1:0] sel_p1;
    logic [23:0]       rgb_p1;

    always_comb begin
        any_hit_p1 = 1'b0;
        sel_p1     = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (hit_p1[i]) begin
                any_hit_p1 = 1'b1;
                sel_p1     = SLOT_W'(i);
            end
        end
`ifdef DRAW_LINES_PER_LINE_COLOR_EN
        rgb_p1 = any_hit_p1 ? col_p1[sel_p1] : 24'h0;
`else
        rgb_p1 = any_hit_p1 ? COLOR : 24'h0;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_out      <= 1'b0;
            hit_slot_out <= '0;
            red_out      <= '0;
            green_out    <= '0;
            blue_out     <= '0;
        end else begin
            hit_out      <= any_hit_p1;
            hit_slot_out <= sel_p1;
            red_out      <= rgb_p1[23:16];
            green_out    <= rgb_p1[15:8];
            blue_out     <= rgb_p1[7:0];
        end
    end

endmodule

// File: doc/draw_lines_multi.md
Name: draw_lines_multi

Overview:
- Parametrised successor to the single-line overlay renderer. Holds up to NUM_LINES line segments in on-chip slots and tests every pixel against all of them through a 3-stage pipeline.
- Emits RGB for the lowest-numbered hit slot.
- Slot writes are double-buffered and commit only at frame start, so a segment never tears mid-frame.
- Sits between the object placement logic and the video mixer.

Parameters:
- NUM_LINES, 4: number of segment slots (1..16).
- TOL, 500: max |cross-product error| still counted as on-line.
- COLOR, 24'hFF_FF_FF: RGB for every hit pixel when per-line colour is compiled out.

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous active-high reset
- hcount_in  input  11  current pixel x
- vcount_in  input  10  current pixel y
- place_valid  input  1  write a segment into the pending bank this cycle
- place_slot  input  $clog2(NUM_LINES)  target slot
- x_in_1 / x_in_2  input  11  endpoint x values
- y_in_1 / y_in_2  input  10  endpoint y values
- clear_all  input  1  invalidate all pending slots
- hit_out  output  1  pixel (delayed 3 cycles) lies on a valid segment
- hit_slot_out  output  $clog2(NUM_LINES)  lowest hit slot index
- red_out / green_out / blue_out  output  8 each  pixel colour, 0 when no hit

Behaviour:
- **Reset:** one cycle of rst_in clears both banks' valid bits, all pipeline registers and all outputs to 0.
- **Write port:** always ready, no backpressure.
  - On place_valid, the pending slot stores endpoints normalised so that x1 <= x2. On an x tie the endpoint order is kept.
  - It also stores dx = x2-x1 (unsigned, 11b) and dy = y2-y1 (signed, 11b), and sets the slot's valid bit.
  - Out-of-range place_slot (>= NUM_LINES) is ignored.
- **clear_all:** clears all pending valid bits. If clear_all and place_valid occur in the same cycle, the clear applies first and the written slot ends valid.
- **Commit:** the whole pending bank copies into the active bank on the cycle where hcount_in==0 and vcount_in==0.
  - A place_valid in that same cycle lands in pending only and is seen the next frame.
- **Pipeline, fixed latency 3, one pixel/cycle, no stalls:**
  - S1: register h/v. Per slot, compute hd = h-x1 (signed 12b) and vd = v-y1 (signed 11b), plus range flag x1<=h<=x2.
  - S2: per slot, register p1 = vd*dx and p2 = hd*dy (signed 24b).
  - S3: per slot, hit = valid && range && |p1-p2| <= TOL, with the difference computed at 25b, no overflow. Priority-encode the lowest hit slot and register the outputs.
- **Vertical segment (dx==0):** hit iff h==x1 and v lies within [min(y1,y2), max(y1,y2)]. This replaces the cross-product test.
- **Degenerate point (both endpoints equal):** hits that single pixel only.
- **Active-bank stability:** the active bank is read only by S1. Slots committed mid-pipeline affect pixels entering S1 from the commit cycle onward.
- **Reset mid-frame:** outputs are 0 the following cycle. The pipeline refills after 3 cycles.

Optional Feature:
- Macro: DRAW_LINES_PER_LINE_COLOR_EN.
- **Defined:** adds an input color_in (24b) captured with each place_valid into the pending slot and committed with it. Output RGB comes from the hit slot's colour; reset colour is 0.
- **Undefined:** no color_in port; every hit uses COLOR.

Decomposition:
- Package draw_lines_pkg:
  - typedef line_seg_t {x1, y1, x2, y2, dx, dy, valid}
  - H_W=11, V_W=10, PROD_W=24 constants
- One natural sub-module, line_hit_test: a per-slot S1/S2/S3 slice producing a hit bit. It is instantiated NUM_LINES times in a generate loop.

Test Plan:
1. Reset, then sweep a frame with no placements -> hit_out=0 and RGB=0 for every pixel.
2. Place slot0 (10,10)-(100,55), then pass frame start -> (56,33) hits 3 cycles later with RGB=FFFFFF. (56,40) misses (|p1-p2| = 630 > 500). (9,10) misses.
3. Place a vertical segment (200,50)-(200,20) -> (200,35) hits. (200,60) and (201,35) miss.
4. Place slot0 (10,10)-(100,55) and slot2 (50,0)-(50,100) -> at (50,30) hit_slot_out=0. With slot0 cleared via clear_all and slot2 re-placed in the same cycle, the next frame gives hit_slot_out=2.
5. Place (300,300)-(400,400) at hcount=5 mid-frame -> no hits until after the next (0,0) commit. Then (350,350) hits.
6. With DRAW_LINES_PER_LINE_COLOR_EN, slot1 color_in=FF0000 -> a hit pixel on slot1 outputs red_out=FF and green_out=blue_out=00. Assert rst_in mid-frame -> all outputs 0 the next cycle.
